// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, active-low HS/VS, pixel position,
// blanking flag and a one-clock frame-start pulse, all from a single clock.
module vga_sync_gen #(
  parameter int DIV    = 4,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       p_tick,
  output logic       HS,
  output logic       VS,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_hs;
  logic             r_vs;
  logic             r_video_on;
  logic             r_frame_start;

  logic             w_tick;
  logic             w_x_wrap;
  logic             w_y_wrap;
  logic [9:0]       w_x_next;
  logic [9:0]       w_y_next;

  function automatic logic hs_active(input logic [9:0] px);
    return (px >= HS_FIRST) && (px <= HS_LAST);
  endfunction

  function automatic logic vs_active(input logic [9:0] py);
    return (py >= VS_FIRST) && (py <= VS_LAST);
  endfunction

  function automatic logic visible(input logic [9:0] px, input logic [9:0] py);
    return (px < H_VIS_W) && (py < V_VIS_W);
  endfunction

  // With DIV=1 the counter is a single bit pinned at 0, so the tick is permanent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_ONE;
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  assign w_x_wrap = (r_x == H_LAST);
  assign w_y_wrap = (r_y == V_LAST);
  assign w_x_next = w_x_wrap ? 10'd0 : r_x + 10'd1;
  assign w_y_next = w_x_wrap ? (w_y_wrap ? 10'd0 : r_y + 10'd1) : r_y;

  // Sync/blank flags are decoded from the next position so they load on the
  // same edge as x/y and never lag the coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_hs          <= !hs_active(10'd0);
      r_vs          <= !vs_active(10'd0);
      r_video_on    <= visible(10'd0, 10'd0);
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && w_x_wrap && w_y_wrap;
      if (w_tick) begin
        r_x        <= w_x_next;
        r_y        <= w_y_next;
        r_hs       <= !hs_active(w_x_next);
        r_vs       <= !vs_active(w_y_next);
        r_video_on <= visible(w_x_next, w_y_next);
      end
    end
  end

  assign p_tick      = rst_n && w_tick;
  assign HS          = r_hs;
  assign VS          = r_vs;
  assign x           = r_x;
  assign y           = r_y;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default, small odd-divider, DIV=1)
// checked against an arithmetic model driven by edges counted since reset release.
module tb_vga_sync_gen;

  localparam int S_DIV = 3;
  localparam int S_HV = 20, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB) * S_DIV;
  localparam int O_VV = 6, O_VF = 1, O_VS = 1, O_VB = 2;
  localparam int O_FRAME = 800 * (O_VV + O_VF + O_VS + O_VB);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       fs;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_s = 1'b0, rst_1 = 1'b0;
  logic pt_a, hs_a, vs_a, von_a, fs_a;
  logic pt_s, hs_s, vs_s, von_s, fs_s;
  logic pt_1, hs_1, vs_1, von_1, fs_1;
  logic [9:0] x_a, y_a, x_s, y_s, x_1, y_1;

  int total = 0;
  int bad   = 0;
  longint e_a, e_s, e_1;

  vga_sync_gen dut_a (
    .clk(clk), .rst_n(rst_a), .p_tick(pt_a), .HS(hs_a), .VS(vs_a),
    .x(x_a), .y(y_a), .video_on(von_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .DIV(S_DIV), .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_s (
    .clk(clk), .rst_n(rst_s), .p_tick(pt_s), .HS(hs_s), .VS(vs_s),
    .x(x_s), .y(y_s), .video_on(von_s), .frame_start(fs_s)
  );

  vga_sync_gen #(
    .DIV(1), .V_VIS(O_VV), .V_FP(O_VF), .V_SYNC(O_VS), .V_BP(O_VB)
  ) dut_1 (
    .clk(clk), .rst_n(rst_1), .p_tick(pt_1), .HS(hs_1), .VS(vs_1),
    .x(x_1), .y(y_1), .video_on(von_1), .frame_start(fs_1)
  );

  // Rising edges seen since each reset was released.
  always @(posedge clk or negedge rst_a) if (!rst_a) e_a <= 0; else e_a <= e_a + 1;
  always @(posedge clk or negedge rst_s) if (!rst_s) e_s <= 0; else e_s <= e_s + 1;
  always @(posedge clk or negedge rst_1) if (!rst_1) e_1 <= 0; else e_1 <= e_1 + 1;

  // After e edges, e/div pixel ticks have been taken; position follows by division.
  function automatic exp_t model(longint e, int div, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb);
    exp_t m;
    int ht, vt, px, py;
    longint p;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = e / div;
    px = int'(p % ht);
    py = int'((p / ht) % vt);
    m.x   = 10'(px);
    m.y   = 10'(py);
    m.hs  = !(px >= hv + hf && px < hv + hf + hsw);
    m.vs  = !(py >= vv + vf && py < vv + vf + vsw);
    m.von = (px < hv) && (py < vv);
    m.pt  = (e % div) == div - 1;
    m.fs  = (e > 0) && (e % div == 0) && (p % (ht * vt) == 0);
    return m;
  endfunction

  function automatic exp_t model_a(longint e);
    return model(e, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic exp_t model_s(longint e);
    return model(e, S_DIV, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
  endfunction
  function automatic exp_t model_1(longint e);
    return model(e, 1, 640, 16, 96, 48, O_VV, O_VF, O_VS, O_VB);
  endfunction

  task automatic test_reset();
    exp_t r;
    r = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1, pt: 1'b0, fs: 1'b0};
    #23;
    total++;
    if ({x_a, y_a, hs_a, vs_a, von_a, pt_a, fs_a} !== r) begin
      bad++; $display("FAIL reset_a got=%h want=%h", {x_a, y_a, hs_a, vs_a, von_a, pt_a, fs_a}, r);
    end
    total++;
    if ({x_s, y_s, hs_s, vs_s, von_s, pt_s, fs_s} !== r) begin
      bad++; $display("FAIL reset_s got=%h want=%h", {x_s, y_s, hs_s, vs_s, von_s, pt_s, fs_s}, r);
    end
    total++;
    if ({x_1, y_1, hs_1, vs_1, von_1, pt_1, fs_1} !== r) begin
      bad++; $display("FAIL reset_div1 got=%h want=%h", {x_1, y_1, hs_1, vs_1, von_1, pt_1, fs_1}, r);
    end
    @(negedge clk);
    #2;
    rst_a = 1'b1; rst_s = 1'b1; rst_1 = 1'b1;
    $display("test_reset done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reset_midframe();
    exp_t m, r;
    longint target;
    target = longint'((3 * 800 + 400) * 4) + longint'($urandom_range(0, 3));
    while (e_a < target) @(negedge clk);
    m = model_a(e_a);
    total++;
    if ({x_a, y_a, hs_a, vs_a, von_a, pt_a, fs_a} !== m || x_a !== 10'd400 || y_a !== 10'd3) begin
      bad++; $display("FAIL pre_reset_pos got=%0d,%0d want=400,3", x_a, y_a);
    end
    #2 rst_a = 1'b0;
    #1;
    r = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b1, pt: 1'b0, fs: 1'b0};
    total++;
    if ({x_a, y_a, hs_a, vs_a, von_a, pt_a, fs_a} !== r) begin
      bad++; $display("FAIL async_reset got=%h want=%h", {x_a, y_a, hs_a, vs_a, von_a, pt_a, fs_a}, r);
    end
    repeat (2) @(negedge clk);
    total++;
    if ({x_a, pt_a} !== {10'd0, 1'b0}) begin
      bad++; $display("FAIL reset_hold got x=%0d pt=%b want x=0 pt=0", x_a, pt_a);
    end
    #3 rst_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if ({pt_a, x_a} !== {k == 3, (k == 4) ? 10'd1 : 10'd0}) begin
        bad++; $display("FAIL release_clk%0d got pt=%b x=%0d want pt=%b x=%0d", k, pt_a, x_a, k == 3, (k == 4) ? 1 : 0);
      end
    end
    $display("test_reset_midframe done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_cadence();
    exp_t m;
    int since_tick, run;
    logic [9:0] prev_x;
    bit seen_change;
    since_tick = -1; run = 0; seen_change = 0;
    @(negedge clk);
    prev_x = x_a;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      m = model_a(e_a);
      total++;
      if ({x_a, y_a, hs_a, vs_a, von_a, pt_a, fs_a} !== m) begin
        bad++; $display("FAIL cadence_model e=%0d got=%h want=%h", e_a, {x_a, y_a, hs_a, vs_a, von_a, pt_a, fs_a}, m);
      end
      if (since_tick >= 0) since_tick++;
      if (pt_a) begin
        if (since_tick > 0) begin
          total++;
          if (since_tick != 4) begin
            bad++; $display("FAIL tick_spacing got=%0d want=4", since_tick);
          end
        end
        since_tick = 0;
      end
      if (x_a != prev_x) begin
        total++;
        if (x_a !== 10'((prev_x + 1) % 800)) begin
          bad++; $display("FAIL x_step got=%0d want=%0d", x_a, (prev_x + 1) % 800);
        end
        if (seen_change) begin
          total++;
          if (run != 4) begin
            bad++; $display("FAIL x_hold x=%0d got=%0d want=4", prev_x, run);
          end
        end
        seen_change = 1; run = 1;
      end else begin
        run++;
      end
      prev_x = x_a;
    end
    $display("test_cadence done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_hsync();
    exp_t m;
    logic prev_hs, prev_von;
    logic [9:0] prev_x;
    int low_run, last_zero;
    low_run = 0; last_zero = -1;
    while (model_a(e_a).x != 10'd650) @(negedge clk);
    prev_hs = hs_a; prev_von = von_a; prev_x = x_a;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      m = model_a(e_a);
      total++;
      if ({x_a, y_a, hs_a, vs_a, von_a, pt_a, fs_a} !== m) begin
        bad++; $display("FAIL hsync_model e=%0d got=%h want=%h", e_a, {x_a, y_a, hs_a, vs_a, von_a, pt_a, fs_a}, m);
      end
      if (!hs_a) low_run++;
      if (prev_hs && !hs_a) begin
        total++;
        if ({prev_x, x_a} !== {10'd655, 10'd656}) begin
          bad++; $display("FAIL hs_fall got x=%0d->%0d want 655->656", prev_x, x_a);
        end
      end
      if (!prev_hs && hs_a) begin
        total++;
        if ({prev_x, x_a} !== {10'd751, 10'd752} || low_run != 384) begin
          bad++; $display("FAIL hs_rise got x=%0d->%0d width=%0d want 751->752 width=384", prev_x, x_a, low_run);
        end
        low_run = 0;
      end
      if (prev_von && !von_a) begin
        total++;
        if ({prev_x, x_a} !== {10'd639, 10'd640}) begin
          bad++; $display("FAIL von_fall got x=%0d->%0d want 639->640", prev_x, x_a);
        end
      end
      if (prev_x == 10'd799 && x_a == 10'd0) begin
        if (last_zero >= 0) begin
          total++;
          if (i - last_zero != 3200) begin
            bad++; $display("FAIL line_period got=%0d want=3200", i - last_zero);
          end
        end
        last_zero = i;
      end
      prev_hs = hs_a; prev_von = von_a; prev_x = x_a;
    end
    $display("test_hsync done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_line_wrap();
    longint target;
    target = longint'((10 * 800 + 799) * 4 + 3);
    while (e_a < target) @(negedge clk);
    total++;
    if ({x_a, y_a, pt_a, vs_a, von_a} !== {10'd799, 10'd10, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL pre_wrap got x=%0d y=%0d pt=%b want 799,10 pt=1", x_a, y_a, pt_a);
    end
    @(negedge clk);
    total++;
    if ({x_a, y_a, fs_a, von_a} !== {10'd0, 10'd11, 1'b0, 1'b1}) begin
      bad++; $display("FAIL line_wrap got x=%0d y=%0d fs=%b want 0,11 fs=0", x_a, y_a, fs_a);
    end
    $display("test_line_wrap done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_frame_small();
    exp_t m;
    int vs_low, von_ticks, bad_von, fs_cnt, last_fs;
    vs_low = 0; von_ticks = 0; bad_von = 0; fs_cnt = 0; last_fs = -1;
    repeat ($urandom_range(40, 1500)) @(negedge clk);
    #2 rst_s = 1'b0;
    #1;
    total++;
    if ({x_s, y_s, hs_s, vs_s, von_s, pt_s, fs_s} !== {10'd0, 10'd0, 5'b11100}) begin
      bad++; $display("FAIL small_async_reset got=%h", {x_s, y_s, hs_s, vs_s, von_s, pt_s, fs_s});
    end
    @(negedge clk);
    #4 rst_s = 1'b1;
    for (int k = 1; k <= 2 * S_FRAME + 3; k++) begin
      @(negedge clk);
      m = model_s(e_s);
      total++;
      if ({x_s, y_s, hs_s, vs_s, von_s, pt_s, fs_s} !== m) begin
        bad++; $display("FAIL small_model e=%0d got=%h want=%h", e_s, {x_s, y_s, hs_s, vs_s, von_s, pt_s, fs_s}, m);
      end
      if (k <= S_FRAME) begin
        if (!vs_s) vs_low++;
        if (pt_s && von_s) von_ticks++;
      end
      if (von_s && y_s >= 10'(S_VV)) bad_von++;
      if (fs_s) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          total++;
          if (k - last_fs != S_FRAME) begin
            bad++; $display("FAIL small_frame_period got=%0d want=%0d", k - last_fs, S_FRAME);
          end
        end
        last_fs = k;
      end
    end
    total++;
    if (vs_low != S_VS * 32 * S_DIV) begin
      bad++; $display("FAIL vs_width got=%0d want=%0d", vs_low, S_VS * 32 * S_DIV);
    end
    total++;
    if (von_ticks != S_HV * S_VV) begin
      bad++; $display("FAIL von_ticks got=%0d want=%0d", von_ticks, S_HV * S_VV);
    end
    total++;
    if (bad_von != 0 || fs_cnt != 2) begin
      bad++; $display("FAIL blank_rows got von_late=%0d fs=%0d want 0 and 2", bad_von, fs_cnt);
    end
    $display("test_frame_small done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_div1();
    exp_t m;
    logic [9:0] prev_x;
    int last_zero, last_fs;
    last_zero = -1; last_fs = -1;
    @(negedge clk);
    prev_x = x_1;
    for (int i = 0; i < 2 * O_FRAME + 100; i++) begin
      @(negedge clk);
      m = model_1(e_1);
      total++;
      if ({x_1, y_1, hs_1, vs_1, von_1, pt_1, fs_1} !== m || pt_1 !== 1'b1 || x_1 !== 10'((prev_x + 1) % 800)) begin
        bad++; $display("FAIL div1_model e=%0d got=%h want=%h", e_1, {x_1, y_1, hs_1, vs_1, von_1, pt_1, fs_1}, m);
      end
      if (x_1 == 10'd0) begin
        if (last_zero >= 0) begin
          total++;
          if (i - last_zero != 800) begin
            bad++; $display("FAIL div1_line got=%0d want=800", i - last_zero);
          end
        end
        last_zero = i;
      end
      if (fs_1) begin
        if (last_fs >= 0) begin
          total++;
          if (i - last_fs != O_FRAME) begin
            bad++; $display("FAIL div1_frame got=%0d want=%0d", i - last_fs, O_FRAME);
          end
        end
        last_fs = i;
      end
      prev_x = x_1;
    end
    $display("test_div1 done total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_cadence();
    test_hsync();
    test_line_wrap();
    test_frame_small();
    test_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator for 640x480 at 60 Hz, driven from the 100 MHz board clock. It produces the pixel-rate enable, active-low HS/VS, the current pixel position `x`/`y`, a `video_on` blanking flag and a one-clock `frame_start` pulse. It sits directly upstream of the pixel/colour stage, which decodes `x`/`y` into RED/GREEN/BLUE. Those colour outputs must be gated by `video_on`.

## Interface

Parameters:
- `DIV`, 4: number of `clk` cycles per pixel (100 MHz / 4 = 25 MHz pixel rate); valid range ≥1.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_VIS`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- Derived values: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).

Ports:
- `clk`, input, 1: system clock, 100 MHz.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `p_tick`, output, 1: pixel enable, high for one `clk` cycle in every `DIV` cycles.
- `HS`, output, 1: horizontal sync, active-low.
- `VS`, output, 1: vertical sync, active-low.
- `x`, output, 10: current column, range 0..H_TOTAL-1.
- `y`, output, 10: current row, range 0..V_TOTAL-1.
- `video_on`, output, 1: high while the current position is inside the visible area.
- `frame_start`, output, 1: one-`clk` pulse when the position wraps to (0,0).

## Operation

- **Divider.**
  - The divider counter counts 0..DIV-1 on every `clk` and wraps back to 0.
  - `p_tick` = (div == DIV-1), gated low while `rst_n` is 0.
  - With DIV=1, `p_tick` is constantly high after reset.
- **Position counters.** `x` and `y` are registers that update only on a `clk` edge where `p_tick` = 1.
  - If x < H_TOTAL-1: x ← x+1.
  - Otherwise: x ← 0, and y ← (y == V_TOTAL-1) ? 0 : y+1.
- **Decoded outputs.** `HS`, `VS` and `video_on` are registered and load together with `x`/`y`, so they always describe the position currently on `x`/`y`. There is no skew.
  - HS = 0 iff H_VIS+H_FP ≤ x ≤ H_VIS+H_FP+H_SYNC-1 (656..751).
  - VS = 0 iff V_VIS+V_FP ≤ y ≤ V_VIS+V_FP+V_SYNC-1 (490..491).
  - video_on = (x < H_VIS) && (y < V_VIS).
- **Frame start.** `frame_start` is registered. It is 1 for exactly the one `clk` cycle following the edge that moves the position from (H_TOTAL-1, V_TOTAL-1) to (0,0). It is not asserted by reset.
- **Reset state.** Position (0,0):
  - div=0, `p_tick`=0.
  - x=0, y=0.
  - HS=1, VS=1.
  - video_on=1, consistent with position (0,0).
  - frame_start=0.
- **Reset mid-operation.** Reset takes effect immediately, independent of `clk`. Counting restarts from the reset state on release.

## Timing

- After `rst_n` rises, `p_tick` first asserts in the DIV-th `clk` cycle (div = DIV-1). `x` becomes 1 at the end of that cycle.
- Every position, including (0,0) after reset, is held for exactly DIV `clk` cycles.
- Line period = H_TOTAL × DIV = 3200 clk.
- Frame period = H_TOTAL × V_TOTAL × DIV = 1,680,000 clk, which is 59.52 Hz at 100 MHz.
- HS low width = H_SYNC × DIV = 384 clk.
- VS low width = V_SYNC × H_TOTAL × DIV = 6400 clk.
- There is zero latency between a position change and its HS/VS/video_on values (same edge).
- `frame_start` rises one edge after (0,0) appears on `x`/`y`. With DIV=4 it falls before the next `p_tick`.

## Test plan

1. **Reset mid-frame.** Assert rst_n=0 at position (400,300), asynchronously between edges.
   - Immediately: x=0, y=0, HS=1, VS=1, video_on=1, p_tick=0.
   - After release: p_tick first high on the 4th clk; x=1 after that edge.
2. **Pixel cadence.** Over 100 pixels, measure the spacing of `p_tick` and the holding time of `x`.
   - Spacing between p_tick pulses = 4 clk.
   - Each x value is held for 4 clk.
   - x increments by exactly 1 per p_tick.
3. **Horizontal sync.** Observe HS across one line.
   - HS falls on the edge x: 655→656 and rises on 751→752.
   - HS is low for 384 clk per line; line period is 3200 clk.
   - video_on falls on x: 639→640.
4. **Line and frame wrap.**
   - (799,10) goes to (0,11).
   - (799,524) goes to (0,0), with frame_start = 1 for exactly 1 clk.
   - Consecutive frame_start pulses are 1,680,000 clk apart.
5. **Vertical sync and blanking.** Check over one frame.
   - VS is low only for y = 490 and 491, for 6400 clk total.
   - video_on is high for exactly 307,200 pixel ticks per frame.
   - video_on = 0 for all y ≥ 480.
6. **DIV=1 instance.**
   - p_tick stays high continuously after reset.
   - x advances every clk.
   - Line period = 800 clk; frame period = 420,000 clk.
